// File: rtl/cevre_istek_hakemi.sv
// Round-robin arbiter sharing one peripheral slave port among N_ISTEKCI requesters.
// One transaction in flight; read responses are routed to the owner, and a silent slave becomes an error response.
module cevre_istek_hakemi #(
  parameter int N_ISTEKCI   = 2,
  parameter int ADRES_BIT   = 32,
  parameter int VERI_BIT    = 32,
  parameter int ZAMAN_ASIMI = 1024
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [N_ISTEKCI*ADRES_BIT-1:0] ist_adres_i,
  input  logic [N_ISTEKCI*VERI_BIT-1:0]  ist_veri_i,
  input  logic [N_ISTEKCI-1:0]           ist_yaz_i,
  input  logic [N_ISTEKCI-1:0]           ist_gecerli_i,
  output logic [N_ISTEKCI-1:0]           ist_hazir_o,
  output logic [VERI_BIT-1:0]            ist_yanit_veri_o,
  output logic [N_ISTEKCI-1:0]           ist_yanit_gecerli_o,
  input  logic [N_ISTEKCI-1:0]           ist_yanit_hazir_i,
  output logic                           ist_hata_o,
  output logic [ADRES_BIT-1:0]           cek_adres_o,
  output logic [VERI_BIT-1:0]            cek_veri_o,
  output logic                           cek_yaz_o,
  output logic                           cek_gecerli_o,
  input  logic                           cek_hazir_i,
  input  logic [VERI_BIT-1:0]            uart_veri_i,
  input  logic                           uart_gecerli_i,
  output logic                           uart_hazir_o
);

  localparam int IDX_BIT   = $clog2(N_ISTEKCI);
  localparam int SAYAC_BIT = $clog2(ZAMAN_ASIMI);
  // The handshake cycle counts as the first timeout cycle, so the error state is entered
  // exactly ZAMAN_ASIMI cycles after the slave accepted the read.
  localparam logic [SAYAC_BIT-1:0] SAYAC_SON = SAYAC_BIT'(ZAMAN_ASIMI - 2);

  typedef enum logic [1:0] {
    BOSTA       = 2'd0,
    ISTEK       = 2'd1,
    YANIT_BEKLE = 2'd2,
    HATA        = 2'd3
  } durum_t;

  durum_t                 durum_r, durum_s;
  logic [IDX_BIT-1:0]     sahip_r, son_r, secim_s;
  logic                   secim_var_s;
  logic [IDX_BIT:0]       aday_s;
  logic [ADRES_BIT-1:0]   adres_r;
  logic [VERI_BIT-1:0]    veri_r;
  logic                   yaz_r;
  logic [SAYAC_BIT-1:0]   sayac_r, sayac_s;

  assign cek_adres_o = adres_r;
  assign cek_veri_o  = veri_r;
  assign cek_yaz_o   = yaz_r;

  // Circular search for the first valid requester after the last granted one.
  always_comb begin
    secim_s     = '0;
    secim_var_s = 1'b0;
    aday_s      = '0;
    for (int i = 1; i <= N_ISTEKCI; i++) begin
      aday_s = {1'b0, son_r} + (IDX_BIT+1)'(i);
      if (aday_s >= (IDX_BIT+1)'(N_ISTEKCI)) begin
        aday_s = aday_s - (IDX_BIT+1)'(N_ISTEKCI);
      end else begin
        aday_s = aday_s;
      end
      if (!secim_var_s && ist_gecerli_i[aday_s[IDX_BIT-1:0]]) begin
        secim_var_s = 1'b1;
        secim_s     = aday_s[IDX_BIT-1:0];
      end else begin
        secim_var_s = secim_var_s;
      end
    end
  end

  // Next state, timeout count and all handshake outputs.
  always_comb begin
    durum_s             = durum_r;
    sayac_s             = sayac_r;
    ist_hazir_o         = '0;
    ist_yanit_gecerli_o = '0;
    ist_yanit_veri_o    = '0;
    ist_hata_o          = 1'b0;
    cek_gecerli_o       = 1'b0;
    uart_hazir_o        = 1'b1;
    case (durum_r)
      BOSTA: begin
        if (secim_var_s) begin
          // Grant is masked while reset is held so every output stays quiet.
          ist_hazir_o[secim_s] = rstn_i;
          durum_s              = ISTEK;
        end else begin
          durum_s = BOSTA;
        end
      end
      ISTEK: begin
        cek_gecerli_o = 1'b1;
        if (cek_hazir_i) begin
          if (yaz_r) begin
            durum_s = BOSTA;
          end else begin
            sayac_s = '0;
            durum_s = YANIT_BEKLE;
          end
        end else begin
          durum_s = ISTEK;
        end
      end
      YANIT_BEKLE: begin
        uart_hazir_o                 = ist_yanit_hazir_i[sahip_r];
        ist_yanit_gecerli_o[sahip_r] = uart_gecerli_i;
        ist_yanit_veri_o             = uart_veri_i;
        if (uart_gecerli_i) begin
          if (ist_yanit_hazir_i[sahip_r]) begin
            durum_s = BOSTA;
          end else begin
            durum_s = YANIT_BEKLE;
          end
        end else if (sayac_r == SAYAC_SON) begin
          durum_s = HATA;
        end else begin
          sayac_s = sayac_r + SAYAC_BIT'(1);
        end
      end
      HATA: begin
        ist_yanit_gecerli_o[sahip_r] = 1'b1;
        ist_yanit_veri_o             = '1;
        ist_hata_o                   = 1'b1;
        if (ist_yanit_hazir_i[sahip_r]) begin
          durum_s = BOSTA;
        end else begin
          durum_s = HATA;
        end
      end
      default: begin
        durum_s = BOSTA;
      end
    endcase
  end

  // State, timeout counter and captured request registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_r <= BOSTA;
      sayac_r <= '0;
      sahip_r <= '0;
      son_r   <= IDX_BIT'(N_ISTEKCI - 1);
      adres_r <= '0;
      veri_r  <= '0;
      yaz_r   <= 1'b0;
    end else begin
      durum_r <= durum_s;
      sayac_r <= sayac_s;
      if (durum_r == BOSTA && secim_var_s) begin
        sahip_r <= secim_s;
        son_r   <= secim_s;
        adres_r <= ist_adres_i[secim_s*ADRES_BIT +: ADRES_BIT];
        veri_r  <= ist_veri_i[secim_s*VERI_BIT +: VERI_BIT];
        yaz_r   <= ist_yaz_i[secim_s];
      end
    end
  end

endmodule
